// File: rtl/pulse_peak_detector.sv
// ---------------------------------------------------------------------------
// pulse_peak_detector
// Receive-side pulse analyzer for a filtered, signed sample stream. Finds
// pulses above THRESHOLD and reports, once per accepted pulse, the peak
// amplitude, the timestamp of the first peak sample, the pulse width and
// whether pile-up (a second rise inside one pulse) was seen.
//
// Ports
//   clk             in   system clock, rising edge
//   reset           in   asynchronous active-low reset
//   input_data      in   signed filtered sample, one per clk
//   event_valid     out  one-clk strobe, event fields valid in that cycle
//   peak_amplitude  out  signed maximum sample of the pulse
//   peak_time       out  timestamp of the first sample equal to the maximum
//   pulse_width     out  number of above-threshold samples
//   pileup          out  pile-up detected within the pulse
//   width_err       out  one-clk strobe when a pulse reaches MAX_WIDTH
//   pulse_count     out  events emitted, saturating at 16'hFFFF
//
// state | meaning
// IDLE  | waiting for a sample above THRESHOLD
// ABOVE | inside a pulse, tracking peak, width, fall and pile-up
// HOLD  | dead time after a pulse ends or aborts; input ignored
// ---------------------------------------------------------------------------
module pulse_peak_detector #(
    parameter int DATA_W    = 16,
    parameter int TS_W      = 32,
    parameter int THRESHOLD = 100,
    parameter int HYST      = 20,
    parameter int MIN_WIDTH = 3,
    parameter int MAX_WIDTH = 64,
    parameter int DEADTIME  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] input_data,
    output logic                     event_valid,
    output logic signed [DATA_W-1:0] peak_amplitude,
    output logic [TS_W-1:0]          peak_time,
    output logic [7:0]               pulse_width,
    output logic                     pileup,
    output logic                     width_err,
    output logic [15:0]              pulse_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ABOVE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic signed [DATA_W-1:0] THR       = DATA_W'(THRESHOLD);
    localparam logic signed [DATA_W:0]   HYST_X    = (DATA_W+1)'(HYST);
    localparam logic [7:0]               MIN_W     = 8'(MIN_WIDTH);
    localparam logic [7:0]               MAX_W     = 8'(MAX_WIDTH);
    localparam logic [7:0]               HOLD_LOAD = 8'(DEADTIME - 1);

    logic signed [DATA_W-1:0] s_q, s_p_q;
    logic [TS_W-1:0]          ts_cnt_q, ts_q;
    logic [1:0]               state_q, state_d;
    logic signed [DATA_W-1:0] peak_q, peak_d;
    logic [TS_W-1:0]          ptime_q, ptime_d;
    logic [7:0]               width_q, width_d;
    logic                     fall_q, fall_d;
    logic                     pile_q, pile_d;
    logic [7:0]               hold_q, hold_d;

    logic                     event_valid_q, event_valid_d;
    logic signed [DATA_W-1:0] peak_amplitude_q, peak_amplitude_d;
    logic [TS_W-1:0]          peak_time_q, peak_time_d;
    logic [7:0]               pulse_width_q, pulse_width_d;
    logic                     pileup_q, pileup_d;
    logic                     width_err_q, width_err_d;
    logic [15:0]              pulse_count_q, pulse_count_d;

    logic                     above;
    logic signed [DATA_W:0]   s_ext, p_ext;
    logic                     rise_ok;
    logic [7:0]               width_inc;

    assign above     = s_q > THR;
    // One extra bit so previous sample + HYST can never wrap.
    assign s_ext     = {s_q[DATA_W-1], s_q};
    assign p_ext     = {s_p_q[DATA_W-1], s_p_q};
    assign rise_ok   = s_ext >= (p_ext + HYST_X);
    assign width_inc = width_q + 8'd1;

    always_comb begin
        state_d          = state_q;
        peak_d           = peak_q;
        ptime_d          = ptime_q;
        width_d          = width_q;
        fall_d           = fall_q;
        pile_d           = pile_q;
        hold_d           = hold_q;
        event_valid_d    = 1'b0;
        width_err_d      = 1'b0;
        peak_amplitude_d = peak_amplitude_q;
        peak_time_d      = peak_time_q;
        pulse_width_d    = pulse_width_q;
        pileup_d         = pileup_q;
        pulse_count_d    = pulse_count_q;

        case (state_q)
            ST_IDLE: begin
                if (above) begin
                    peak_d  = s_q;
                    ptime_d = ts_q;
                    width_d = 8'd1;
                    fall_d  = 1'b0;
                    pile_d  = 1'b0;
                    state_d = ST_ABOVE;
                end
            end
            ST_ABOVE: begin
                if (above) begin
                    width_d = width_inc;
                    if (s_q > peak_q) begin
                        peak_d  = s_q;
                        ptime_d = ts_q;
                    end
                    if (s_q < s_p_q) begin
                        fall_d = 1'b1;
                    end
                    if (fall_q && rise_ok) begin
                        pile_d = 1'b1;
                    end
                    if (width_inc == MAX_W) begin
                        width_err_d = 1'b1;
                        hold_d      = HOLD_LOAD;
                        state_d     = ST_HOLD;
                    end
                end else begin
                    if (width_q >= MIN_W) begin
                        event_valid_d    = 1'b1;
                        peak_amplitude_d = peak_q;
                        peak_time_d      = ptime_q;
                        pulse_width_d    = width_q;
                        pileup_d         = pile_q;
                        if (pulse_count_q != 16'hFFFF) begin
                            pulse_count_d = pulse_count_q + 16'd1;
                        end
                    end
                    hold_d  = HOLD_LOAD;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q              <= '0;
            s_p_q            <= '0;
            ts_cnt_q         <= '0;
            ts_q             <= '0;
            state_q          <= ST_IDLE;
            peak_q           <= '0;
            ptime_q          <= '0;
            width_q          <= '0;
            fall_q           <= 1'b0;
            pile_q           <= 1'b0;
            hold_q           <= '0;
            event_valid_q    <= 1'b0;
            peak_amplitude_q <= '0;
            peak_time_q      <= '0;
            pulse_width_q    <= '0;
            pileup_q         <= 1'b0;
            width_err_q      <= 1'b0;
            pulse_count_q    <= '0;
        end else begin
            s_q              <= input_data;
            s_p_q            <= s_q;
            ts_q             <= ts_cnt_q;
            ts_cnt_q         <= ts_cnt_q + TS_W'(1);
            state_q          <= state_d;
            peak_q           <= peak_d;
            ptime_q          <= ptime_d;
            width_q          <= width_d;
            fall_q           <= fall_d;
            pile_q           <= pile_d;
            hold_q           <= hold_d;
            event_valid_q    <= event_valid_d;
            peak_amplitude_q <= peak_amplitude_d;
            peak_time_q      <= peak_time_d;
            pulse_width_q    <= pulse_width_d;
            pileup_q         <= pileup_d;
            width_err_q      <= width_err_d;
            pulse_count_q    <= pulse_count_d;
        end
    end

    assign event_valid    = event_valid_q;
    assign peak_amplitude = peak_amplitude_q;
    assign peak_time      = peak_time_q;
    assign pulse_width    = pulse_width_q;
    assign pileup         = pileup_q;
    assign width_err      = width_err_q;
    assign pulse_count    = pulse_count_q;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// ---------------------------------------------------------------------------
// tb_pulse_peak_detector
// Directed scenarios plus a randomized stream checked against a pulse-level
// reference model (scans the sample list for pulses and derives each event
// from its samples directly).
// ---------------------------------------------------------------------------
module tb_pulse_peak_detector;

    localparam int THR   = 100;
    localparam int HYST  = 20;
    localparam int MIN_W = 3;
    localparam int MAX_W = 64;
    localparam int DEAD  = 4;

    typedef struct {
        logic signed [15:0] amp;
        logic [31:0]        ptime;
        logic [7:0]         width;
        logic               pile;
        logic [15:0]        count;
        int unsigned        at;
    } ev_t;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] input_data;
    logic               event_valid;
    logic signed [15:0] peak_amplitude;
    logic [31:0]        peak_time;
    logic [7:0]         pulse_width;
    logic               pileup;
    logic               width_err;
    logic [15:0]        pulse_count;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    int unsigned        cnt;
    ev_t                obs_ev[$];
    ev_t                exp_ev[$];
    ev_t                mon_e;
    int unsigned        obs_err[$];
    int unsigned        exp_err[$];
    logic signed [15:0] smp_log[$];
    int unsigned        ts_log[$];
    int                 stim[$];
    logic [15:0]        exp_count;
    logic [15:0]        model_count;

    pulse_peak_detector dut (
        .clk            (clk),
        .reset          (reset),
        .input_data     (input_data),
        .event_valid    (event_valid),
        .peak_amplitude (peak_amplitude),
        .peak_time      (peak_time),
        .pulse_width    (pulse_width),
        .pileup         (pileup),
        .width_err      (width_err),
        .pulse_count    (pulse_count)
    );

    always #5 clk = ~clk;

    // Reference timestamp: number of rising edges since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) cnt <= 0;
        else        cnt <= cnt + 1;
    end

    always @(negedge clk) begin
        if (event_valid === 1'b1) begin
            mon_e.amp   = peak_amplitude;
            mon_e.ptime = peak_time;
            mon_e.width = pulse_width;
            mon_e.pile  = pileup;
            mon_e.count = pulse_count;
            mon_e.at    = cnt;
            obs_ev.push_back(mon_e);
        end
        if (width_err === 1'b1) obs_err.push_back(cnt);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int v);
        @(negedge clk);
        input_data = 16'(v);
        smp_log.push_back(16'(v));
        ts_log.push_back(cnt);
    endtask

    task automatic clear_logs();
        obs_ev.delete();
        obs_err.delete();
        smp_log.delete();
        ts_log.delete();
    endtask

    task automatic play();
        clear_logs();
        foreach (stim[i]) drive(stim[i]);
        repeat (DEAD + 6) drive(0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b0;
        input_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Pulse-level reference: walk the logged samples, carve out pulses,
    // derive each event from its samples, then skip the dead time.
    task automatic model(input logic [15:0] cnt0);
        int n, i, k, w, pk, pidx, ff, a, b;
        bit pile;
        logic [15:0] c;
        ev_t e;
        exp_ev.delete();
        exp_err.delete();
        n = smp_log.size();
        c = cnt0;
        i = 0;
        while (i < n) begin
            if (int'(smp_log[i]) <= THR) begin
                i++;
                continue;
            end
            w = 0;
            k = i;
            while (k < n && int'(smp_log[k]) > THR) begin
                w++;
                if (w == MAX_W) break;
                k++;
            end
            if (k >= n) break;
            if (w == MAX_W) begin
                exp_err.push_back(ts_log[k] + 2);
                i = k + 1 + DEAD;
                continue;
            end
            if (w >= MIN_W) begin
                pk   = int'(smp_log[i]);
                pidx = i;
                for (int m = i + 1; m < k; m++) begin
                    if (int'(smp_log[m]) > pk) begin
                        pk   = int'(smp_log[m]);
                        pidx = m;
                    end
                end
                pile = 1'b0;
                ff   = -1;
                for (int m = i + 1; m < k; m++) begin
                    a = int'(smp_log[m-1]);
                    b = int'(smp_log[m]);
                    if (ff < 0) begin
                        if (b < a) ff = m;
                    end else if (b >= a + HYST) begin
                        pile = 1'b1;
                    end
                end
                if (c != 16'hFFFF) c = c + 16'd1;
                e.amp   = 16'(pk);
                e.ptime = ts_log[pidx];
                e.width = 8'(w);
                e.pile  = pile;
                e.count = c;
                e.at    = ts_log[k] + 2;
                exp_ev.push_back(e);
            end
            i = k + 1 + DEAD;
        end
        model_count = c;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        input_data = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({event_valid, peak_amplitude, peak_time, pulse_width, pileup, width_err, pulse_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: outputs amp=%0d width=%0d count=%0d, expected all 0", peak_amplitude, pulse_width, pulse_count);
        end
        reset = 1'b1;
        stim = '{0, 150, 300, 250, 120, 50};
        play();
        n_checks++;
        if (obs_ev.size() !== 1) begin
            n_fail++;
            $display("FAIL reset_prepulse: %0d events, expected 1", obs_ev.size());
        end
        clear_logs();
        drive(0);
        drive(500);
        drive(500);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({event_valid, peak_amplitude, peak_time, pulse_width, pileup, width_err, pulse_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_midpulse: amp=%0d width=%0d count=%0d, expected all 0", peak_amplitude, pulse_width, pulse_count);
        end
        repeat (2) @(negedge clk);
        @(negedge clk);
        input_data = '0;
        reset      = 1'b1;
        clear_logs();
        repeat (12) drive(0);
        n_checks++;
        if (obs_ev.size() !== 0 || obs_err.size() !== 0 || pulse_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_discard: events=%0d errs=%0d count=%0d, expected 0 0 0", obs_ev.size(), obs_err.size(), pulse_count);
        end
        exp_count = 16'd0;
    endtask

    task automatic test_single_pulse();
        stim = '{0, 150, 300, 250, 120, 50};
        play();
        exp_count = exp_count + 16'd1;
        n_checks++;
        if (obs_ev.size() !== 1) begin
            n_fail++;
            $display("FAIL single_events: %0d events, expected 1", obs_ev.size());
        end
        if (obs_ev.size() >= 1) begin
            n_checks++;
            if (obs_ev[0].amp !== 16'sd300 || obs_ev[0].width !== 8'd4 || obs_ev[0].pile !== 1'b0) begin
                n_fail++;
                $display("FAIL single_fields: amp=%0d width=%0d pile=%0b, expected 300 4 0", obs_ev[0].amp, obs_ev[0].width, obs_ev[0].pile);
            end
            n_checks++;
            if (obs_ev[0].ptime !== ts_log[2] || obs_ev[0].count !== exp_count) begin
                n_fail++;
                $display("FAIL single_time_count: ptime=%0d count=%0d, expected %0d %0d", obs_ev[0].ptime, obs_ev[0].count, ts_log[2], exp_count);
            end
            n_checks++;
            if (obs_ev[0].at !== ts_log[5] + 2) begin
                n_fail++;
                $display("FAIL single_latency: event at %0d, expected %0d", obs_ev[0].at, ts_log[5] + 2);
            end
        end
    endtask

    task automatic test_short_pulse();
        stim = '{0, 200, 200, 50, 100, 100, 100, 100, 100, 100, 100, 100};
        play();
        n_checks++;
        if (obs_ev.size() !== 0 || pulse_count !== exp_count) begin
            n_fail++;
            $display("FAIL short_discard: events=%0d count=%0d, expected 0 %0d", obs_ev.size(), pulse_count, exp_count);
        end
        n_checks++;
        if (peak_amplitude !== 16'sd300 || pulse_width !== 8'd4 || event_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL short_hold: amp=%0d width=%0d valid=%0b, expected 300 4 0", peak_amplitude, pulse_width, event_valid);
        end
    endtask

    task automatic test_pileup();
        stim = '{0, 150, 300, 200, 180, 260, 120, 50};
        play();
        exp_count = exp_count + 16'd1;
        n_checks++;
        if (obs_ev.size() !== 1) begin
            n_fail++;
            $display("FAIL pileup_events: %0d events, expected 1", obs_ev.size());
        end
        if (obs_ev.size() >= 1) begin
            n_checks++;
            if (obs_ev[0].amp !== 16'sd300 || obs_ev[0].width !== 8'd6 || obs_ev[0].pile !== 1'b1 || obs_ev[0].count !== exp_count) begin
                n_fail++;
                $display("FAIL pileup_fields: amp=%0d width=%0d pile=%0b count=%0d, expected 300 6 1 %0d", obs_ev[0].amp, obs_ev[0].width, obs_ev[0].pile, obs_ev[0].count, exp_count);
            end
        end
        stim = '{0, 150, 300, 200, 180, 190, 120, 50};
        play();
        exp_count = exp_count + 16'd1;
        n_checks++;
        if (obs_ev.size() !== 1) begin
            n_fail++;
            $display("FAIL nopile_events: %0d events, expected 1", obs_ev.size());
        end
        if (obs_ev.size() >= 1) begin
            n_checks++;
            if (obs_ev[0].width !== 8'd6 || obs_ev[0].pile !== 1'b0 || obs_ev[0].count !== exp_count) begin
                n_fail++;
                $display("FAIL nopile_fields: width=%0d pile=%0b count=%0d, expected 6 0 %0d", obs_ev[0].width, obs_ev[0].pile, obs_ev[0].count, exp_count);
            end
        end
    endtask

    task automatic test_width_err();
        stim.delete();
        stim.push_back(0);
        repeat (132) stim.push_back(200);
        play();
        n_checks++;
        if (obs_err.size() !== 2) begin
            n_fail++;
            $display("FAIL werr_count: %0d width_err pulses, expected 2", obs_err.size());
        end
        if (obs_err.size() >= 2) begin
            n_checks++;
            if (obs_err[0] !== ts_log[64] + 2 || obs_err[1] !== ts_log[132] + 2) begin
                n_fail++;
                $display("FAIL werr_timing: at %0d,%0d, expected %0d,%0d", obs_err[0], obs_err[1], ts_log[64] + 2, ts_log[132] + 2);
            end
        end
        n_checks++;
        if (obs_ev.size() !== 0 || pulse_count !== exp_count) begin
            n_fail++;
            $display("FAIL werr_noevent: events=%0d count=%0d, expected 0 %0d", obs_ev.size(), pulse_count, exp_count);
        end
    endtask

    task automatic test_deadtime();
        stim = '{0, 150, 300, 250, 120, 50, 0, 150, 0, 150, 150, 150, 150, 0};
        play();
        n_checks++;
        if (obs_ev.size() !== 2) begin
            n_fail++;
            $display("FAIL dead_events: %0d events, expected 2", obs_ev.size());
        end
        if (obs_ev.size() >= 2) begin
            n_checks++;
            if (obs_ev[1].amp !== 16'sd150 || obs_ev[1].width !== 8'd3 || obs_ev[1].ptime !== ts_log[10]) begin
                n_fail++;
                $display("FAIL dead_retrigger: amp=%0d width=%0d ptime=%0d, expected 150 3 %0d", obs_ev[1].amp, obs_ev[1].width, obs_ev[1].ptime, ts_log[10]);
            end
            n_checks++;
            if (obs_ev[1].count !== exp_count + 16'd2 || obs_ev[1].at !== ts_log[13] + 2) begin
                n_fail++;
                $display("FAIL dead_count: count=%0d at=%0d, expected %0d %0d", obs_ev[1].count, obs_ev[1].at, exp_count + 16'd2, ts_log[13] + 2);
            end
        end
        exp_count = exp_count + 16'd2;
    endtask

    task automatic test_saturate();
        @(negedge clk);
        force dut.pulse_count_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.pulse_count_q;
        exp_count = 16'hFFFF;
        stim = '{0, 150, 300, 250, 120, 50};
        play();
        n_checks++;
        if (obs_ev.size() !== 1) begin
            n_fail++;
            $display("FAIL sat_events: %0d events, expected 1", obs_ev.size());
        end
        if (obs_ev.size() >= 1) begin
            n_checks++;
            if (obs_ev[0].count !== exp_count) begin
                n_fail++;
                $display("FAIL sat_event_count: count=%0h, expected %0h", obs_ev[0].count, exp_count);
            end
        end
        n_checks++;
        if (pulse_count !== exp_count) begin
            n_fail++;
            $display("FAIL sat_hold: count=%0h, expected %0h", pulse_count, exp_count);
        end
    endtask

    task automatic test_random();
        int gap, kind, len, v;
        do_reset();
        clear_logs();
        for (int p = 0; p < 45; p++) begin
            gap = $urandom_range(0, 6);
            for (int g = 0; g < gap; g++) begin
                v = int'($urandom_range(0, 400)) - 300;
                if ($urandom_range(0, 9) == 0) v = -32768;
                if ($urandom_range(0, 9) == 0) v = THR;
                drive(v);
            end
            kind = $urandom_range(0, 11);
            len  = (kind == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(1, 9));
            for (int l = 0; l < len; l++) begin
                v = int'($urandom_range(101, 500));
                if (kind == 1 && l == len / 2) v = 32767;
                if ($urandom_range(0, 7) == 0) v = THR + 1;
                drive(v);
            end
        end
        repeat (DEAD + 6) drive(0);
        model(16'd0);
        n_checks++;
        if (obs_ev.size() !== exp_ev.size()) begin
            n_fail++;
            $display("FAIL rand_event_count: %0d events, expected %0d", obs_ev.size(), exp_ev.size());
        end
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            n_checks++;
            if (obs_ev[i] !== exp_ev[i]) begin
                n_fail++;
                $display("FAIL rand_event[%0d]: amp=%0d ptime=%0d width=%0d pile=%0b count=%0d at=%0d, expected amp=%0d ptime=%0d width=%0d pile=%0b count=%0d at=%0d",
                         i, obs_ev[i].amp, obs_ev[i].ptime, obs_ev[i].width, obs_ev[i].pile, obs_ev[i].count, obs_ev[i].at,
                         exp_ev[i].amp, exp_ev[i].ptime, exp_ev[i].width, exp_ev[i].pile, exp_ev[i].count, exp_ev[i].at);
            end
        end
        n_checks++;
        if (obs_err !== exp_err) begin
            n_fail++;
            $display("FAIL rand_width_err: %0d pulses, expected %0d", obs_err.size(), exp_err.size());
        end
        n_checks++;
        if (pulse_count !== model_count) begin
            n_fail++;
            $display("FAIL rand_pulse_count: count=%0d, expected %0d", pulse_count, model_count);
        end
    endtask

    initial begin
        reset      = 1'b0;
        input_data = '0;
        exp_count  = '0;
        test_reset();
        test_single_pulse();
        test_short_pulse();
        test_pileup();
        test_width_err();
        test_deadtime();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
